// File: rtl/ucom_timer_bank_if.sv
// CPU-side command/readback bus of the uCOM timer bank: load strobe, acknowledge strobe
// and counter readback.
interface ucom_timer_bank_if #(
  parameter int unsigned CH_W  = 1,
  parameter int unsigned CNT_W = 6
);
  logic             ld;
  logic [CH_W-1:0]  ld_ch;
  logic [CNT_W-1:0] ld_val;
  logic             ld_per;
  logic             ack;
  logic [CH_W-1:0]  ack_ch;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_cnt;

  modport master (
    output ld, ld_ch, ld_val, ld_per, ack, ack_ch, rd_ch,
    input  rd_cnt
  );

  modport slave (
    input  ld, ld_ch, ld_val, ld_per, ack, ack_ch, rd_ch,
    output rd_cnt
  );
endinterface

// File: rtl/ucom_timer_bank.sv
// Multi-channel STM-style interval timer. Each channel has a prescaler, a down-counter,
// and one-shot or periodic reload, with expiry and overrun flags and a masked interrupt.
module ucom_timer_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PRE_W    = 6,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned CH_W     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  ucom_timer_bank_if.slave    bus,
  input  logic [CHANNELS-1:0] ien_mask,
  output logic [CHANNELS-1:0] tm,
  output logic [CHANNELS-1:0] ovr,
  output logic                irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           st_q  [CHANNELS];
  state_t           st_d  [CHANNELS];
  logic [PRE_W-1:0] pre_q [CHANNELS];
  logic [PRE_W-1:0] pre_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic [CNT_W-1:0] rld_q [CHANNELS];
  logic [CNT_W-1:0] rld_d [CHANNELS];

  logic [CHANNELS-1:0] per_q, per_d;
  logic [CHANNELS-1:0] tm_q, tm_d;
  logic [CHANNELS-1:0] ovr_q, ovr_d;
  logic                irq_q;
  logic [CHANNELS-1:0] ld_hit, ack_hit;
  logic [CNT_W-1:0]    rd_mux;

  // Out-of-range channel indices match no channel, so their strobes are dropped.
  always_comb begin
    ld_hit  = '0;
    ack_hit = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      ld_hit[k]  = bus.ld  && (bus.ld_ch  == CH_W'(k));
      ack_hit[k] = bus.ack && (bus.ack_ch == CH_W'(k));
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      st_d[k]  = st_q[k];
      pre_d[k] = pre_q[k];
      cnt_d[k] = cnt_q[k];
      rld_d[k] = rld_q[k];
    end
    per_d = per_q;
    tm_d  = tm_q;
    ovr_d = ovr_q;

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ld_hit[k]) begin
        pre_d[k] = '0;
        cnt_d[k] = bus.ld_val;
        rld_d[k] = bus.ld_val;
        per_d[k] = bus.ld_per;
        tm_d[k]  = 1'b0;
        ovr_d[k] = 1'b0;
        st_d[k]  = RUN;
      end else begin
        if (ack_hit[k]) begin
          tm_d[k]  = 1'b0;
          ovr_d[k] = 1'b0;
          if (st_q[k] == DONE) begin
            st_d[k] = IDLE;
          end
        end
        // Expiry is applied after the ack so a coincident new event survives the ack.
        if ((st_q[k] == RUN) && tick) begin
          if (cnt_q[k] == '0) begin
            if (per_q[k]) begin
              ovr_d[k] = ovr_d[k] | tm_d[k];
              tm_d[k]  = 1'b1;
              pre_d[k] = '0;
              cnt_d[k] = rld_q[k];
            end else begin
              tm_d[k]  = 1'b1;
              st_d[k]  = DONE;
            end
          end else begin
            pre_d[k] = pre_q[k] + 1'b1;
            if (pre_q[k] == '1) begin
              cnt_d[k] = cnt_q[k] - 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        st_q[k]  <= IDLE;
        pre_q[k] <= '0;
        cnt_q[k] <= '0;
        rld_q[k] <= '0;
      end
      per_q <= '0;
      tm_q  <= '0;
      ovr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        st_q[k]  <= st_d[k];
        pre_q[k] <= pre_d[k];
        cnt_q[k] <= cnt_d[k];
        rld_q[k] <= rld_d[k];
      end
      per_q <= per_d;
      tm_q  <= tm_d;
      ovr_q <= ovr_d;
      irq_q <= |(tm_q & ien_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.rd_ch == CH_W'(k)) begin
        rd_mux = cnt_q[k];
      end
    end
  end

  assign bus.rd_cnt = rd_mux;
  assign tm         = tm_q;
  assign ovr        = ovr_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_ucom_timer_bank.sv
// Self-checking bench for ucom_timer_bank: directed scenarios plus a randomized run,
// all compared against an elapsed-tick reference model.
module tb_ucom_timer_bank;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned PRE_W    = 2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CH_W     = 1;
  localparam int          PRE_N    = 1 << PRE_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                tick;
  logic [CHANNELS-1:0] ien_mask;
  logic [CHANNELS-1:0] tm;
  logic [CHANNELS-1:0] ovr;
  logic                irq;

  ucom_timer_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus_if ();

  ucom_timer_bank #(
    .CHANNELS(CHANNELS),
    .PRE_W(PRE_W),
    .CNT_W(CNT_W),
    .CH_W(CH_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .bus(bus_if.slave),
    .ien_mask(ien_mask),
    .tm(tm),
    .ovr(ovr),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a channel expires once it has counted val*2^PRE_W ticks and sees one more.
  int m_val [CHANNELS];
  int m_el  [CHANNELS];
  bit m_per [CHANNELS];
  bit m_run [CHANNELS];
  bit m_done[CHANNELS];
  bit m_tm  [CHANNELS];
  bit m_ovr [CHANNELS];
  bit m_irq;

  function automatic int m_cnt(input int k);
    return m_run[k] ? (m_val[k] - m_el[k] / PRE_N) : 0;
  endfunction

  function automatic logic [CHANNELS-1:0] m_tm_vec();
    logic [CHANNELS-1:0] v;
    for (int k = 0; k < CHANNELS; k++) v[k] = m_tm[k];
    return v;
  endfunction

  function automatic logic [CHANNELS-1:0] m_ovr_vec();
    logic [CHANNELS-1:0] v;
    for (int k = 0; k < CHANNELS; k++) v[k] = m_ovr[k];
    return v;
  endfunction

  task automatic step(input bit t);
    bit irq_n;
    tick = t;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        m_val[k] = 0; m_el[k] = 0; m_per[k] = 0; m_run[k] = 0;
        m_done[k] = 0; m_tm[k] = 0; m_ovr[k] = 0;
      end
      m_irq = 0;
    end else begin
      irq_n = 0;
      for (int k = 0; k < CHANNELS; k++) irq_n |= m_tm[k] & ien_mask[k];
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus_if.ld && int'(bus_if.ld_ch) == k) begin
          m_val[k] = int'(bus_if.ld_val); m_per[k] = bus_if.ld_per; m_el[k] = 0;
          m_run[k] = 1; m_done[k] = 0; m_tm[k] = 0; m_ovr[k] = 0;
        end else begin
          if (bus_if.ack && int'(bus_if.ack_ch) == k) begin
            m_tm[k] = 0; m_ovr[k] = 0; m_done[k] = 0;
          end
          if (m_run[k] && t) begin
            if (m_el[k] == m_val[k] * PRE_N) begin
              if (m_per[k]) begin
                if (m_tm[k]) m_ovr[k] = 1;
                m_tm[k] = 1; m_el[k] = 0;
              end else begin
                m_tm[k] = 1; m_run[k] = 0; m_done[k] = 1;
              end
            end else begin
              m_el[k]++;
            end
          end
        end
      end
      m_irq = irq_n;
    end
    #1;
    bus_if.ld  = 1'b0;
    bus_if.ack = 1'b0;
  endtask

  task automatic do_ld(input int ch, input int val, input bit per);
    bus_if.ld     = 1'b1;
    bus_if.ld_ch  = CH_W'(ch);
    bus_if.ld_val = CNT_W'(val);
    bus_if.ld_per = per;
  endtask

  task automatic do_ack(input int ch);
    bus_if.ack    = 1'b1;
    bus_if.ack_ch = CH_W'(ch);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    do_ld(0, 5, 1);
    step(1);
    step(0);
    checks++; if (tm !== 2'b00) begin errors++; $display("FAIL reset_tm got=%b exp=00", tm); end
    checks++; if (ovr !== 2'b00) begin errors++; $display("FAIL reset_ovr got=%b exp=00", ovr); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    for (int k = 0; k < CHANNELS; k++) begin
      bus_if.rd_ch = CH_W'(k); #1;
      checks++;
      if (bus_if.rd_cnt !== 4'd0) begin
        errors++; $display("FAIL reset_rd_cnt ch%0d got=%0d exp=0", k, bus_if.rd_cnt);
      end
    end
    reset = 1'b0;
    bus_if.rd_ch = '0;
    step(0);
  endtask

  task automatic test_oneshot();
    int n;
    bit got;
    bit seen;
    bus_if.rd_ch = 1'b0;
    do_ld(0, 3, 0);
    step(0);
    n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1); n++;
      checks++;
      if (bus_if.rd_cnt !== 4'(m_cnt(0))) begin
        errors++; $display("FAIL oneshot_cnt tick%0d got=%0d exp=%0d", n, bus_if.rd_cnt, m_cnt(0));
      end
      if (tm[0]) got = 1; else step(0);
    end
    checks++; if (!got || n != 13) begin errors++; $display("FAIL oneshot_expiry_tick got=%0d exp=13", n); end
    for (int i = 0; i < 10; i++) begin step(0); step(1); end
    checks++; if (bus_if.rd_cnt !== 4'd0) begin errors++; $display("FAIL oneshot_frozen got=%0d exp=0", bus_if.rd_cnt); end
    checks++; if (tm[0] !== 1'b1) begin errors++; $display("FAIL oneshot_hold got=%b exp=1", tm[0]); end
    do_ack(0);
    step(0);
    checks++; if (tm[0] !== 1'b0) begin errors++; $display("FAIL oneshot_ack got=%b exp=0", tm[0]); end
    seen = 0;
    for (int i = 0; i < 50; i++) begin step(1); step(0); if (tm[0]) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL oneshot_no_reexpiry got=1 exp=0"); end
  endtask

  task automatic test_zero_load();
    ien_mask = 2'b10;
    do_ld(1, 0, 0);
    step(0);
    step(1);
    checks++; if (tm[1] !== 1'b1) begin errors++; $display("FAIL zero_tm got=%b exp=1", tm[1]); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL zero_irq_early got=%b exp=0", irq); end
    step(0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL zero_irq got=%b exp=1", irq); end
    ien_mask = 2'b00;
    step(0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL zero_irq_masked got=%b exp=0", irq); end
      step(i[0]);
    end
    do_ack(1);
    step(0);
  endtask

  task automatic test_periodic();
    int exp_t[3] = '{9, 18, 27};
    int got_t[$];
    int first_ovr;
    do_ld(0, 2, 1);
    step(0);
    for (int t = 1; t <= 27; t++) begin
      step(1);
      checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL periodic_ovr tick%0d got=1 exp=0", t); end
      if (tm[0]) begin got_t.push_back(t); do_ack(0); end
      step(0);
    end
    checks++;
    if (got_t.size() != 3) begin
      errors++; $display("FAIL periodic_count got=%0d exp=3", got_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_t[i] != exp_t[i]) begin
          errors++; $display("FAIL periodic_tick%0d got=%0d exp=%0d", i, got_t[i], exp_t[i]);
        end
      end
    end
    do_ld(0, 2, 1);
    step(0);
    first_ovr = 0;
    for (int t = 1; t <= 20; t++) begin
      step(1);
      if (ovr[0] && first_ovr == 0) first_ovr = t;
      step(0);
    end
    checks++; if (first_ovr != 18) begin errors++; $display("FAIL periodic_overrun_tick got=%0d exp=18", first_ovr); end
  endtask

  task automatic test_collisions();
    bus_if.rd_ch = 1'b0;
    do_ld(0, 0, 1);
    step(0);
    step(1);
    checks++; if (tm[0] !== 1'b1) begin errors++; $display("FAIL coll_first_expiry got=%b exp=1", tm[0]); end
    step(0);
    do_ack(0);
    step(1);
    checks++; if (tm[0] !== 1'b1) begin errors++; $display("FAIL coll_ack_expiry_tm got=%b exp=1", tm[0]); end
    checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL coll_ack_expiry_ovr got=%b exp=0", ovr[0]); end
    step(0);
    step(1);
    checks++; if (ovr[0] !== 1'b1) begin errors++; $display("FAIL coll_plain_overrun got=%b exp=1", ovr[0]); end
    do_ld(0, 7, 0);
    do_ack(0);
    step(1);
    checks++; if (tm[0] !== 1'b0) begin errors++; $display("FAIL coll_ld_ack_tm got=%b exp=0", tm[0]); end
    checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL coll_ld_ack_ovr got=%b exp=0", ovr[0]); end
    checks++; if (bus_if.rd_cnt !== 4'd7) begin errors++; $display("FAIL coll_ld_ack_cnt got=%0d exp=7", bus_if.rd_cnt); end
    for (int i = 0; i < 4; i++) begin step(0); step(1); end
    checks++; if (bus_if.rd_cnt !== 4'd6) begin errors++; $display("FAIL coll_ld_running got=%0d exp=6", bus_if.rd_cnt); end
  endtask

  task automatic test_reload();
    int n;
    do_ld(1, 6, 0);
    step(0);
    do_ld(0, 5, 0);
    step(0);
    for (int i = 0; i < 7; i++) begin step(1); step(0); end
    do_ld(0, 1, 0);
    step(0);
    n = 0;
    bus_if.rd_ch = 1'b0;
    for (int i = 0; i < 30 && !tm[0]; i++) begin
      step(1); n++;
      if (!tm[0]) step(0);
    end
    checks++; if (n != 5 || !tm[0]) begin errors++; $display("FAIL reload_expiry_ticks got=%0d exp=5", n); end
    bus_if.rd_ch = 1'b1; #1;
    checks++; if (bus_if.rd_cnt !== 4'd3) begin errors++; $display("FAIL reload_ch1_cnt got=%0d exp=3", bus_if.rd_cnt); end
    checks++; if (tm[1] !== 1'b0) begin errors++; $display("FAIL reload_ch1_tm got=%b exp=0", tm[1]); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    ien_mask = 2'b11;
    do_ld(1, 1, 1);
    step(0);
    do_ld(0, 3, 0);
    step(0);
    for (int i = 0; i < 20 && !tm[1]; i++) begin step(1); step(0); end
    checks++; if (tm[1] !== 1'b1) begin errors++; $display("FAIL rstmid_setup_tm1 got=%b exp=1", tm[1]); end
    reset = 1'b1;
    do_ld(0, 2, 0);
    step(1);
    reset = 1'b0;
    checks++; if (tm !== 2'b00) begin errors++; $display("FAIL rstmid_tm got=%b exp=00", tm); end
    checks++; if (ovr !== 2'b00) begin errors++; $display("FAIL rstmid_ovr got=%b exp=00", ovr); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
    for (int k = 0; k < CHANNELS; k++) begin
      bus_if.rd_ch = CH_W'(k); #1;
      checks++;
      if (bus_if.rd_cnt !== 4'd0) begin
        errors++; $display("FAIL rstmid_rd_cnt ch%0d got=%0d exp=0", k, bus_if.rd_cnt);
      end
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(1); step(0); if (tm != 2'b00 || irq) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_expiry got=1 exp=0"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) begin
        do_ld($urandom_range(0, 1),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
              $urandom_range(0, 1) != 0);
      end
      if ($urandom_range(0, 3) == 0) do_ack($urandom_range(0, 1));
      ien_mask     = CHANNELS'($urandom_range(0, 3));
      bus_if.rd_ch = CH_W'($urandom_range(0, 1));
      step($urandom_range(0, 1) != 0);
      checks++; if (tm !== m_tm_vec()) begin errors++; $display("FAIL rand_tm cyc%0d got=%b exp=%b", i, tm, m_tm_vec()); end
      checks++; if (ovr !== m_ovr_vec()) begin errors++; $display("FAIL rand_ovr cyc%0d got=%b exp=%b", i, ovr, m_ovr_vec()); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc%0d got=%b exp=%b", i, irq, m_irq); end
      checks++;
      if (bus_if.rd_cnt !== 4'(m_cnt(int'(bus_if.rd_ch)))) begin
        errors++;
        $display("FAIL rand_rd_cnt cyc%0d ch%0d got=%0d exp=%0d", i, bus_if.rd_ch, bus_if.rd_cnt,
                 m_cnt(int'(bus_if.rd_ch)));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    tick          = 1'b0;
    ien_mask      = '0;
    bus_if.ld     = 1'b0;
    bus_if.ld_ch  = '0;
    bus_if.ld_val = '0;
    bus_if.ld_per = 1'b0;
    bus_if.ack    = 1'b0;
    bus_if.ack_ch = '0;
    bus_if.rd_ch  = '0;
    test_reset();
    test_oneshot();
    test_zero_load();
    test_periodic();
    test_collisions();
    test_reload();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
